// File: rtl/product_accumulator.sv
// Signed product accumulator with guard bits, saturated registered output,
// sticky overflow, product counter and a two-state ACC/HOLD result handshake.
`timescale 1ns/1ps
module product_accumulator #(
    parameter int WIDTH = 32,
    parameter int GUARD = 8,
    parameter int CNT_W = 8,
    localparam int PW   = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    product,
    input  logic             last,
    input  logic             clear,
    output logic [PW-1:0]    acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] count,
    output logic             dbg_state
);

    localparam int AW = PW + GUARD;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    // Handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; ready never depends on valid, and valid holds until transfer.
    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_acc, w_acc_next, w_prod_ext, w_sum;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_overflow, w_overflow_next;
    logic [PW-1:0]    r_acc_out;
    logic             w_xfer;

    // Outside the 64-bit signed range when the bits above the product sign differ.
    function automatic logic out_of_range(input logic [AW-1:0] v);
        return !((&v[AW-1:PW-1]) || !(|v[AW-1:PW-1]));
    endfunction

    function automatic logic [PW-1:0] saturate(input logic [AW-1:0] v);
        if (!out_of_range(v))
            return v[PW-1:0];
        else if (v[AW-1])
            return {1'b1, {(PW-1){1'b0}}};
        else
            return {1'b0, {(PW-1){1'b1}}};
    endfunction

    assign in_ready   = en && rst && (r_state == ACC);
    assign w_xfer     = in_valid && in_ready;
    assign w_prod_ext = {{GUARD{product[PW-1]}}, product};
    assign w_sum      = r_acc + w_prod_ext;

    always_comb begin
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        case (r_state)
            ACC: begin
                if (w_xfer) begin
                    if (clear) begin
                        w_acc_next      = w_prod_ext;
                        w_count_next    = CNT_W'(1);
                        w_overflow_next = out_of_range(w_prod_ext);
                    end else if (r_count == CNT_MAX) begin
                        // Counter full: the product is consumed but dropped.
                        w_overflow_next = 1'b1;
                    end else begin
                        w_acc_next      = w_sum;
                        w_count_next    = r_count + CNT_W'(1);
                        w_overflow_next = r_overflow || out_of_range(w_sum);
                    end
                    if (last)
                        w_state_next = HOLD;
                end else if (en && clear) begin
                    w_acc_next      = '0;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_acc_next      = '0;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                    w_state_next    = ACC;
                end
            end
            default: w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_acc_out  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
            r_acc_out  <= saturate(w_acc_next);
        end
    end

    assign acc_out   = r_acc_out;
    assign out_valid = (r_state == HOLD);
    assign overflow  = r_overflow;
    assign count     = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: stimulus pushes expected final
// results into a queue; a negedge monitor pops them on each output transfer.
`timescale 1ns/1ps
module tb_product_accumulator;

    localparam int PW    = 64;
    localparam int CNT_W = 8;
    localparam int EW    = PW + CNT_W + 1;
    localparam logic signed [PW-1:0] P62  = 64'sh4000_0000_0000_0000;
    localparam logic signed [PW-1:0] N62  = -64'sh4000_0000_0000_0000;
    localparam logic signed [PW-1:0] SMAX = 64'sh7fff_ffff_ffff_ffff;
    localparam logic signed [PW-1:0] SMIN = 64'sh8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b1;
    logic             in_valid = 1'b0;
    logic             last = 1'b0;
    logic             clear = 1'b0;
    logic             out_ready = 1'b1;
    logic [PW-1:0]    product = '0;
    logic             in_ready, out_valid, overflow, dbg_state;
    logic [PW-1:0]    acc_out;
    logic [CNT_W-1:0] count;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int n_cmp = 0;
    int n_err = 0;

    product_accumulator dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .last(last), .clear(clear), .acc_out(acc_out),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .count(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected acc_out=%0d count=%0d overflow=%0b",
                         $signed(acc_out), count, overflow);
            end else begin
                mon_e = exp_q.pop_front();
                if ({acc_out, count, overflow} !== mon_e) begin
                    n_err++;
                    $display("FAIL result actual acc_out=%0d count=%0d overflow=%0b required acc_out=%0d count=%0d overflow=%0b",
                             $signed(acc_out), count, overflow,
                             $signed(mon_e[EW-1:CNT_W+1]), mon_e[CNT_W:1], mon_e[0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic signed [PW-1:0] act,
                       input logic signed [PW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
        end
    endtask

    task automatic expect_result(input logic signed [PW-1:0] a,
                                 input logic [CNT_W-1:0] c, input logic o);
        exp_q.push_back({a, c, o});
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic signed [PW-1:0] p, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        product  = p;
        last     = l;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    initial begin
        int waited;
        // Reset values, with en already high
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        resync();

        // Basic sequence
        expect_result(1395, 4, 1'b0);
        send(-384, 1'b0);
        send(75, 1'b0);
        chk("partial_acc", acc_out, -309);
        chk("partial_count", count, 2);
        send(204, 1'b0);
        send(1500, 1'b1);
        chk("hold_valid", out_valid, 1);
        resync();
        chk("valid_one_cycle", out_valid, 0);
        chk("post_drain_acc", acc_out, 0);
        chk("post_drain_count", count, 0);
        chk("post_drain_ready", in_ready, 1);

        // Saturation both ways, then sticky overflow back in range
        expect_result(SMAX, 3, 1'b1);
        send(P62, 1'b0);
        send(P62, 1'b0);
        chk("ovf_early", overflow, 1);
        chk("sat_early", acc_out, SMAX);
        send(P62, 1'b1);
        resync();
        expect_result(SMIN, 3, 1'b1);
        send(N62, 1'b0);
        send(N62, 1'b0);
        send(N62, 1'b1);
        resync();
        expect_result(P62, 3, 1'b1);
        send(P62, 1'b0);
        send(P62, 1'b0);
        send(N62, 1'b1);
        resync();

        // Backpressure in HOLD
        out_ready = 1'b0;
        expect_result(260, 1, 1'b0);
        send(260, 1'b1);
        in_valid = 1'b1;
        product  = 12;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_acc_out", acc_out, 260);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_state", dbg_state, 1);
        end
        resync();
        out_ready = 1'b1;
        expect_result(12, 1, 1'b0);
        send(12, 1'b1);
        resync();

        // Clear with and without a coinciding transfer
        send(75, 1'b0);
        clear = 1'b1;
        send(12, 1'b0);
        chk("clear_xfer_acc", acc_out, 12);
        chk("clear_xfer_count", count, 1);
        resync();
        clear = 1'b0;
        chk("clear_acc", acc_out, 0);
        chk("clear_count", count, 0);
        send(P62, 1'b0);
        send(P62, 1'b0);
        clear = 1'b1;
        resync();
        clear = 1'b0;
        chk("clear_overflow", overflow, 0);

        // Clear ignored in HOLD
        out_ready = 1'b0;
        send(5, 1'b1);
        clear = 1'b1;
        resync();
        clear = 1'b0;
        chk("hold_clear_acc", acc_out, 5);
        chk("hold_clear_count", count, 1);
        chk("hold_clear_valid", out_valid, 1);
        expect_result(5, 1, 1'b0);
        out_ready = 1'b1;
        resync();

        // Asynchronous reset mid-sequence
        send(12, 1'b0);
        send(-864, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_acc", acc_out, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_ready", in_ready, 0);
        resync();
        rst = 1'b1;
        expect_result(13, 1, 1'b0);
        send(13, 1'b1);
        resync();

        // Enable low holds input side; output still drains
        send(7, 1'b0);
        en       = 1'b0;
        in_valid = 1'b1;
        product  = 1234;
        repeat (3) begin
            @(negedge clk);
            chk("en_in_ready", in_ready, 0);
            chk("en_count", count, 1);
            chk("en_acc_out", acc_out, 7);
        end
        resync();
        in_valid  = 1'b0;
        en        = 1'b1;
        out_ready = 1'b0;
        expect_result(27, 2, 1'b0);
        send(20, 1'b1);
        en        = 1'b0;
        out_ready = 1'b1;
        resync();
        chk("en_drain_valid", out_valid, 0);
        chk("en_drain_ready", in_ready, 0);
        chk("en_drain_count", count, 0);
        en = 1'b1;

        // Counter saturation: the 256th product is accepted but dropped
        expect_result(255, 255, 1'b1);
        for (int i = 0; i < 255; i++)
            send(1, 1'b0);
        chk("cnt_full_count", count, 255);
        chk("cnt_full_ovf", overflow, 0);
        send(1, 1'b1);
        resync();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
